axi_stream_frame_chk: RTL and testbench

Downstream sink/checker for the video AXI4-Stream produced by the test-pattern generator. It accepts beats under a programmable TREADY backpressure pattern, measures line length and frame height from TUSER[0] (start of frame, SOF) and TLAST (end of line, EOL), and checks geometry and the test-pattern TDATA fields. It keeps saturating error and frame counters for register readout. It sits at the tail of the video_ctrl pipeline and exercises the generator's backpressure handling.

---
 rtl/axi_stream_vid_pkg.sv | 29 ++
 rtl/axi4_stream_if.sv | 22 ++
 rtl/axi_stream_ready_gen.sv | 52 +++++
 rtl/axi_stream_frame_chk.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi_stream_frame_chk.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stream_vid_pkg.sv
// Shared types and TDATA field layout for the video test-pattern stream
// and its downstream frame checker.
package axi_stream_vid_pkg;

    localparam int unsigned DIM_W       = 11;
    localparam int unsigned FLD_W       = 8;
    localparam int unsigned TD_LINE_LSB = 0;
    localparam int unsigned TD_PIX_LSB  = 8;
    localparam int unsigned TD_FRM_LSB  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        IN_FRAME = 2'd2
    } chk_state_e;

    typedef enum logic [1:0] {
        RDY_ALWAYS = 2'd0,
        RDY_3OF4   = 2'd1,
        RDY_LFSR   = 2'd2,
        RDY_NEVER  = 2'd3
    } tready_mode_e;

    // Saturating increment for pixel/line geometry counters.
    function automatic logic [DIM_W-1:0] dim_sat_inc(input logic [DIM_W-1:0] v);
        return (v == {DIM_W{1'b1}}) ? v : v + DIM_W'(1);
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle for the video path; m is the sink view.
interface axi4_stream_if (
    input logic ACLK,
    input logic ARESETn
);
    logic [31:0] TDATA;
    logic [3:0]  TKEEP;
    logic [0:0]  TUSER;
    logic        TVALID;
    logic        TLAST;
    logic        TREADY;

    modport m (
        input  ACLK, ARESETn, TDATA, TKEEP, TUSER, TVALID, TLAST,
        output TREADY
    );

    modport s (
        input  ACLK, ARESETn, TREADY,
        output TDATA, TKEEP, TUSER, TVALID, TLAST
    );
endinterface

// File: rtl/axi_stream_ready_gen.sv
// Registered TREADY pattern generator: always, 3-of-4, LFSR-random or never.
module axi_stream_ready_gen
    import axi_stream_vid_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode_i,
    input  logic       active_i,
    output logic       tready_o
);

    logic [1:0]   phase_q, phase_d;
    logic [15:0]  lfsr_q, lfsr_d;
    logic         tready_q, tready_d;
    logic         fb_c;
    logic         rdy_c;
    tready_mode_e mode_c;

    always_comb begin
        mode_c   = tready_mode_e'(mode_i);
        phase_d  = phase_q + 2'd1;
        // Fibonacci taps 16,14,13,11
        fb_c     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], fb_c};
        rdy_c    = 1'b0;
        case (mode_c)
            RDY_ALWAYS: rdy_c = 1'b1;
            RDY_3OF4:   rdy_c = (phase_q != 2'd3);
            RDY_LFSR:   rdy_c = lfsr_q[0];
            RDY_NEVER:  rdy_c = 1'b0;
            default:    rdy_c = 1'b0;
        endcase
        tready_d = active_i & rdy_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= 2'd0;
            lfsr_q   <= LFSR_SEED;
            tready_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            lfsr_q   <= lfsr_d;
            tready_q <= tready_d;
        end
    end

    assign tready_o = tready_q;

endmodule

// File: rtl/axi_stream_frame_chk.sv
// Video AXI4-Stream sink: measures line/frame geometry from SOF/EOL,
// checks test-pattern TDATA fields and keeps saturating error counters.
module axi_stream_frame_chk
    import axi_stream_vid_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    axi4_stream_if.m          axi_stream_i,
    input  logic              chk_enable_i,
    input  logic [DIM_W-1:0]  exp_width_i,
    input  logic [DIM_W-1:0]  exp_height_i,
    input  logic              data_chk_en_i,
    input  logic [1:0]        tready_mode_i,
    input  logic              clr_i,
    output logic [DIM_W-1:0]  meas_width_o,
    output logic [DIM_W-1:0]  meas_height_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [CNT_W-1:0]  err_sof_o,
    output logic [CNT_W-1:0]  err_eol_o,
    output logic [CNT_W-1:0]  err_data_o,
    output logic              locked_o
);

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic        clk, rst_n;
    logic        tready;
    logic        beat_c, sof_c, tlast_c, en_rise_c;
    logic [31:0] tdata_c;
    logic        unused_bits_c;

    assign clk           = axi_stream_i.ACLK;
    assign rst_n         = axi_stream_i.ARESETn;
    assign sof_c         = axi_stream_i.TUSER[0];
    assign tlast_c       = axi_stream_i.TLAST;
    assign tdata_c       = axi_stream_i.TDATA;
    assign beat_c        = axi_stream_i.TVALID & tready;
    assign unused_bits_c = ^{axi_stream_i.TKEEP, tdata_c[31:24]};

    logic en_s1_q, en_s2_q, en_prev_q;
    assign en_rise_c = en_s2_q & ~en_prev_q;

    chk_state_e             state_q, state_d;
    logic [DIM_W-1:0]       pix_q, pix_d, line_q, line_d;
    logic [DIM_W-1:0]       exp_w_q, exp_w_d, exp_h_q, exp_h_d;
    logic [FLD_W-1:0]       frm_q, frm_d;
    logic                   frame_err_q, frame_err_d;
    logic                   late_q, late_d;
    logic                   need_sof_q, need_sof_d;
    logic                   good_q, good_d;
    logic                   locked_q, locked_d;
    logic [DIM_W-1:0]       meas_w_q, meas_w_d, meas_h_q, meas_h_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]       err_sof_q, err_sof_d, err_eol_q, err_eol_d, err_data_q, err_data_d;

    logic                   sof_inc_c, eol_inc_c, data_inc_c, frm_inc_c;
    logic [DIM_W-1:0]       pix_b, line_b;
    logic [FLD_W-1:0]       frm_b;
    logic                   ferr_b, late_b;

    // Next-state, geometry and error evaluation for one beat.
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        line_d      = line_q;
        exp_w_d     = exp_w_q;
        exp_h_d     = exp_h_q;
        frm_d       = frm_q;
        frame_err_d = frame_err_q;
        late_d      = late_q;
        need_sof_d  = need_sof_q;
        good_d      = good_q;
        meas_w_d    = meas_w_q;
        meas_h_d    = meas_h_q;
        frame_cnt_d = frame_cnt_q;
        err_sof_d   = err_sof_q;
        err_eol_d   = err_eol_q;
        err_data_d  = err_data_q;
        sof_inc_c   = 1'b0;
        eol_inc_c   = 1'b0;
        data_inc_c  = 1'b0;
        frm_inc_c   = 1'b0;
        pix_b       = pix_q;
        line_b      = line_q;
        frm_b       = frm_q;
        ferr_b      = frame_err_q;
        late_b      = late_q;

        if (!en_s2_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_rise_c) begin
                        state_d = WAIT_SOF;
                        exp_w_d = exp_width_i;
                        exp_h_d = exp_height_i;
                    end
                end
                WAIT_SOF, IN_FRAME: begin
                    if (beat_c) begin
                        if (state_q == IN_FRAME && need_sof_q && !sof_c) begin
                            sof_inc_c  = 1'b1;
                            state_d    = WAIT_SOF;
                            need_sof_d = 1'b0;
                        end else if (state_q == IN_FRAME || sof_c) begin
                            // A SOF beat is pixel 0 of line 0 of a fresh frame.
                            if (sof_c) begin
                                sof_inc_c = (state_q == IN_FRAME) &&
                                            (pix_q != '0 || line_q != '0);
                                pix_b  = '0;
                                line_b = '0;
                                ferr_b = 1'b0;
                                late_b = 1'b0;
                                frm_b  = tdata_c[TD_FRM_LSB +: FLD_W];
                            end
                            state_d    = IN_FRAME;
                            need_sof_d = 1'b0;
                            frm_d      = frm_b;

                            data_inc_c = data_chk_en_i &&
                                ((tdata_c[TD_LINE_LSB +: FLD_W] != line_b[FLD_W-1:0]) ||
                                 (tdata_c[TD_PIX_LSB  +: FLD_W] != pix_b[FLD_W-1:0])  ||
                                 (tdata_c[TD_FRM_LSB  +: FLD_W] != frm_b));

                            if (tlast_c && ((12'(pix_b) + 12'd1) < 12'(exp_w_q)))
                                eol_inc_c = 1'b1;
                            if (!tlast_c && !late_b && (pix_b == exp_w_q - DIM_W'(1))) begin
                                eol_inc_c = 1'b1;
                                late_b    = 1'b1;
                            end
                            ferr_b = ferr_b | eol_inc_c | data_inc_c;

                            if (tlast_c) begin
                                meas_w_d = dim_sat_inc(pix_b);
                                pix_d    = '0;
                                late_d   = 1'b0;
                                if (line_b == exp_h_q - DIM_W'(1)) begin
                                    meas_h_d    = dim_sat_inc(line_b);
                                    frm_inc_c   = ~ferr_b;
                                    line_d      = '0;
                                    need_sof_d  = 1'b1;
                                    frame_err_d = 1'b0;
                                end else begin
                                    line_d      = dim_sat_inc(line_b);
                                    frame_err_d = ferr_b;
                                end
                            end else begin
                                pix_d       = dim_sat_inc(pix_b);
                                line_d      = line_b;
                                late_d      = late_b;
                                frame_err_d = ferr_b;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Clear wins over any increment in the same cycle.
        if (clr_i) begin
            frame_cnt_d = '0;
            err_sof_d   = '0;
            err_eol_d   = '0;
            err_data_d  = '0;
            good_d      = 1'b0;
        end else begin
            if (sof_inc_c)  err_sof_d   = cnt_sat_inc(err_sof_q);
            if (eol_inc_c)  err_eol_d   = cnt_sat_inc(err_eol_q);
            if (data_inc_c) err_data_d  = cnt_sat_inc(err_data_q);
            if (frm_inc_c) begin
                frame_cnt_d = cnt_sat_inc(frame_cnt_q);
                good_d      = 1'b1;
            end
        end

        locked_d = (state_d == IN_FRAME) && good_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1_q     <= 1'b0;
            en_s2_q     <= 1'b0;
            en_prev_q   <= 1'b0;
            state_q     <= IDLE;
            pix_q       <= '0;
            line_q      <= '0;
            exp_w_q     <= '0;
            exp_h_q     <= '0;
            frm_q       <= '0;
            frame_err_q <= 1'b0;
            late_q      <= 1'b0;
            need_sof_q  <= 1'b0;
            good_q      <= 1'b0;
            locked_q    <= 1'b0;
            meas_w_q    <= '0;
            meas_h_q    <= '0;
            frame_cnt_q <= '0;
            err_sof_q   <= '0;
            err_eol_q   <= '0;
            err_data_q  <= '0;
        end else begin
            en_s1_q     <= chk_enable_i;
            en_s2_q     <= en_s1_q;
            en_prev_q   <= en_s2_q;
            state_q     <= state_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            exp_w_q     <= exp_w_d;
            exp_h_q     <= exp_h_d;
            frm_q       <= frm_d;
            frame_err_q <= frame_err_d;
            late_q      <= late_d;
            need_sof_q  <= need_sof_d;
            good_q      <= good_d;
            locked_q    <= locked_d;
            meas_w_q    <= meas_w_d;
            meas_h_q    <= meas_h_d;
            frame_cnt_q <= frame_cnt_d;
            err_sof_q   <= err_sof_d;
            err_eol_q   <= err_eol_d;
            err_data_q  <= err_data_d;
        end
    end

    // TREADY registers from the next state so enable-to-ready is 3 cycles.
    axi_stream_ready_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_ready_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_i   (tready_mode_i),
        .active_i (state_d != IDLE),
        .tready_o (tready)
    );

    assign axi_stream_i.TREADY = tready;
    assign meas_width_o  = meas_w_q;
    assign meas_height_o = meas_h_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign err_sof_o     = err_sof_q;
    assign err_eol_o     = err_eol_q;
    assign err_data_o    = err_data_q;
    assign locked_o      = locked_q;

endmodule

// File: tb/tb_axi_stream_frame_chk.sv
// Directed bench for axi_stream_frame_chk: 8x4 frames, error injection,
// saturation (4-bit counters), clear priority and reset behaviour.
module tb_axi_stream_frame_chk;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          chk_en;
    logic [10:0]   exp_w, exp_h;
    logic          dchk;
    logic [1:0]    mode;
    logic          clr;
    logic [10:0]   meas_w, meas_h;
    logic [CW-1:0] frame_cnt, err_sof, err_eol, err_data;
    logic          locked;

    int checks   = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    axi4_stream_if axis (.ACLK(clk), .ARESETn(rst_n));

    axi_stream_frame_chk #(.CNT_W(CW), .LFSR_SEED(16'hACE1)) dut (
        .axi_stream_i  (axis),
        .chk_enable_i  (chk_en),
        .exp_width_i   (exp_w),
        .exp_height_i  (exp_h),
        .data_chk_en_i (dchk),
        .tready_mode_i (mode),
        .clr_i         (clr),
        .meas_width_o  (meas_w),
        .meas_height_o (meas_h),
        .frame_cnt_o   (frame_cnt),
        .err_sof_o     (err_sof),
        .err_eol_o     (err_eol),
        .err_data_o    (err_data),
        .locked_o      (locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] px(input int l, input int p, input int f);
        logic [7:0] junk;
        junk = 8'($urandom);
        return {junk, 8'(f), 8'(p), 8'(l)};
    endfunction

    // One beat; waits (bounded) for TREADY, which is stable around negedge.
    task automatic beat(input logic sof, input logic last, input logic [31:0] data);
        int n;
        n = 0;
        axis.TVALID = 1'b1;
        axis.TUSER  = sof;
        axis.TLAST  = last;
        axis.TDATA  = data;
        while (axis.TREADY !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            assert (axis.TREADY === 1'b1) else begin
                failures++;
                $error("FAIL tready_timeout: observed %b expected 1", axis.TREADY);
            end
        end
        @(posedge clk);
        @(negedge clk);
        axis.TVALID = 1'b0;
        axis.TUSER  = 1'b0;
        axis.TLAST  = 1'b0;
    endtask

    task automatic send_line(input int l, input int n, input int f, input int bad_pix);
        logic [31:0] d;
        for (int p = 0; p < n; p++) begin
            d = px(l, p, f);
            if (p == bad_pix) d = d ^ 32'h0000_0100;
            beat(l == 0 && p == 0, p == n - 1, d);
        end
    endtask

    task automatic send_frame(input int f, input int bad_line, input int bad_pix);
        for (int l = 0; l < 4; l++)
            send_line(l, 8, f, (l == bad_line) ? bad_pix : -1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        chk_en = 1'b0; exp_w = 11'd8; exp_h = 11'd4;
        dchk = 1'b1; mode = 2'd0; clr = 1'b0;
        axis.TVALID = 1'b0; axis.TUSER = 1'b0; axis.TLAST = 1'b0;
        axis.TDATA = 32'h0; axis.TKEEP = 4'hF;
        idle(3);

        check("rst_tready",    32'(axis.TREADY), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_err_sof",   32'(err_sof), 0);
        check("rst_err_eol",   32'(err_eol), 0);
        check("rst_err_data",  32'(err_data), 0);
        check("rst_meas_w",    32'(meas_w), 0);
        check("rst_locked",    32'(locked), 0);

        rst_n = 1'b1;
        idle(2);
        chk_en = 1'b1;
        idle(2);
        check("en_lat_2cyc", 32'(axis.TREADY), 0);
        idle(1);
        check("en_lat_3cyc", 32'(axis.TREADY), 1);

        // Clean 3-frame stream, always ready.
        for (int f = 1; f <= 3; f++) send_frame(f, -1, -1);
        idle(2);
        check("clean_frame_cnt", 32'(frame_cnt), 3);
        check("clean_meas_w",    32'(meas_w), 8);
        check("clean_meas_h",    32'(meas_h), 4);
        check("clean_err_sof",   32'(err_sof), 0);
        check("clean_err_eol",   32'(err_eol), 0);
        check("clean_err_data",  32'(err_data), 0);
        check("clean_locked",    32'(locked), 1);

        // Same stream under LFSR backpressure.
        pulse_clr();
        check("clr_frame_cnt", 32'(frame_cnt), 0);
        mode = 2'd2;
        for (int f = 4; f <= 6; f++) send_frame(f, -1, -1);
        idle(2);
        check("bp_frame_cnt", 32'(frame_cnt), 3);
        check("bp_meas_w",    32'(meas_w), 8);
        check("bp_meas_h",    32'(meas_h), 4);
        check("bp_err_data",  32'(err_data), 0);
        check("bp_err_eol",   32'(err_eol), 0);
        mode = 2'd0;

        // Early EOL: line 2 closes after 6 pixels.
        pulse_clr();
        send_line(0, 8, 7, -1);
        send_line(1, 8, 7, -1);
        send_line(2, 6, 7, -1);
        check("short_meas_w",   32'(meas_w), 6);
        check("short_err_eol",  32'(err_eol), 1);
        send_line(3, 8, 7, -1);
        check("short_frame_cnt", 32'(frame_cnt), 0);
        check("short_meas_h",   32'(meas_h), 4);
        send_frame(8, -1, -1);
        check("after_short_frame_cnt", 32'(frame_cnt), 1);

        // Missing SOF after a frame end.
        beat(1'b0, 1'b0, px(0, 0, 9));
        check("nosof_err_sof", 32'(err_sof), 1);
        check("nosof_locked",  32'(locked), 0);
        send_frame(9, -1, -1);
        check("nosof_frame_cnt", 32'(frame_cnt), 2);
        check("nosof_relock",    32'(locked), 1);

        // SOF injected at pix=3 on line 1; the restarted frame completes.
        pulse_clr();
        send_line(0, 8, 10, -1);
        for (int p = 0; p < 3; p++) beat(1'b0, 1'b0, px(1, p, 10));
        beat(1'b1, 1'b0, px(0, 0, 11));
        check("inj_err_sof", 32'(err_sof), 1);
        for (int p = 1; p < 8; p++) beat(1'b0, p == 7, px(0, p, 11));
        for (int l = 1; l < 4; l++) send_line(l, 8, 11, -1);
        check("inj_frame_cnt", 32'(frame_cnt), 1);
        send_frame(12, -1, -1);
        check("inj_next_frame_cnt", 32'(frame_cnt), 2);
        check("inj_err_eol", 32'(err_eol), 0);

        // Corrupted pixel field with and without the data check.
        pulse_clr();
        send_frame(13, 1, 4);
        check("dchk_on_err_data",  32'(err_data), 1);
        check("dchk_on_frame_cnt", 32'(frame_cnt), 0);
        pulse_clr();
        dchk = 1'b0;
        send_frame(14, 1, 4);
        check("dchk_off_err_data",  32'(err_data), 0);
        check("dchk_off_frame_cnt", 32'(frame_cnt), 1);
        dchk = 1'b1;

        // Drive err_data into saturation, then clear during an error beat.
        pulse_clr();
        beat(1'b1, 1'b0, 32'h00AA_AA55);
        for (int i = 0; i < 19; i++) beat(1'b0, 1'b0, 32'h00AA_AA55);
        check("sat_err_data", 32'(err_data), 15);
        check("sat_err_eol",  32'(err_eol), 1);
        clr = 1'b1;
        beat(1'b0, 1'b0, 32'h00AA_AA55);
        clr = 1'b0;
        check("clr_prio_err_data", 32'(err_data), 0);
        beat(1'b0, 1'b0, 32'h00AA_AA55);
        check("post_clr_err_data", 32'(err_data), 1);

        // Reset mid-frame after a clean frame.
        send_frame(15, -1, -1);
        beat(1'b0, 1'b0, px(0, 1, 15));
        check("pre_rst_frame_cnt", 32'(frame_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tready",    32'(axis.TREADY), 0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        check("mid_rst_err_data",  32'(err_data), 0);
        check("mid_rst_meas_w",    32'(meas_w), 0);
        check("mid_rst_meas_h",    32'(meas_h), 0);
        check("mid_rst_locked",    32'(locked), 0);
        @(negedge clk);
        chk_en = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("post_rst_idle_tready", 32'(axis.TREADY), 0);

        // Re-enable, one clean frame, then disable.
        chk_en = 1'b1;
        idle(3);
        send_frame(16, -1, -1);
        check("reen_frame_cnt", 32'(frame_cnt), 1);
        check("reen_meas_h",    32'(meas_h), 4);
        chk_en = 1'b0;
        idle(3);
        check("dis_tready",    32'(axis.TREADY), 0);
        check("dis_locked",    32'(locked), 0);
        check("dis_frame_cnt", 32'(frame_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
